// File: rtl/game_ui_pkg.sv
// Shared types and defaults for the game-UI sequencer: state enum, health-bar
// field widths and the default ROM address / time widths.
package game_ui_pkg;

    localparam int DEF_ADDR_WIDTH    = 10;
    localparam int DEF_MAXIMUM_TIMES = 30;

    localparam int HB_X_W    = 10;
    localparam int HB_Y_W    = 10;
    localparam int HB_W_W    = 10;
    localparam int HB_H_W    = 10;
    localparam int HB_SENS_W = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ACK,
        ST_WAIT,
        ST_ADV,
        ST_DONE
    } ui_state_e;

    // The time base only runs while an entry is being fetched or held.
    function automatic logic is_busy_state(input ui_state_e s);
        return (s == ST_FETCH) || (s == ST_ACK) || (s == ST_WAIT);
    endfunction

endpackage

// File: rtl/game_ui_sequencer_time_base.sv
// Game time base: a TICK_DIV prescaler feeding a saturating time counter.
// Clear has priority over enable.
module game_time_base #(
    parameter int MAXIMUM_TIMES = 30,
    parameter int TICK_DIV      = 100000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clear,
    output logic [MAXIMUM_TIMES-1:0] current_time
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]            prescaler_q, prescaler_d;
    logic [MAXIMUM_TIMES-1:0] time_q, time_d;

    always_comb begin
        prescaler_d = prescaler_q;
        time_d      = time_q;
        if (clear) begin
            prescaler_d = '0;
            time_d      = '0;
        end else if (enable) begin
            if (prescaler_q == PRE_LAST) begin
                prescaler_d = '0;
                // Saturate rather than wrap so a long wait never releases early.
                if (time_q != '1) begin
                    time_d = time_q + MAXIMUM_TIMES'(1);
                end
            end else begin
                prescaler_d = prescaler_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_q <= '0;
            time_q      <= '0;
        end else begin
            prescaler_q <= prescaler_d;
            time_q      <= time_d;
        end
    end

    assign current_time = time_q;

endmodule

// File: rtl/game_ui_sequencer.sv
// Runtime controller for the game-UI ROM reader: steps the ROM address, runs the
// time base and latches each decoded health-bar entry. Define UI_SEQ_LOOP_EN to
// restart the sequence at the end marker instead of stopping in DONE.
module game_ui_sequencer
    import game_ui_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int MAXIMUM_TIMES = DEF_MAXIMUM_TIMES,
    parameter int TICK_DIV      = 100000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     pause,
    input  logic                     update_ui_time,
    input  logic [MAXIMUM_TIMES-1:0] next_ui_time,
    input  logic                     is_end,
    input  logic                     rom_reset_hs,
    input  logic [HB_X_W-1:0]        rom_x,
    input  logic [HB_Y_W-1:0]        rom_y,
    input  logic [HB_W_W-1:0]        rom_w,
    input  logic [HB_H_W-1:0]        rom_h,
    input  logic [HB_SENS_W-1:0]     rom_sens,
    output logic [ADDR_WIDTH-1:0]    addr,
    output logic [MAXIMUM_TIMES-1:0] current_time,
    output logic                     sync_ui_time,
    output logic [HB_X_W-1:0]        hb_x,
    output logic [HB_Y_W-1:0]        hb_y,
    output logic [HB_W_W-1:0]        hb_w,
    output logic [HB_H_W-1:0]        hb_h,
    output logic [HB_SENS_W-1:0]     hb_sens,
    output logic                     hb_reset_pulse,
    output logic                     busy,
    output logic                     seq_done
);

    ui_state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [MAXIMUM_TIMES-1:0] t_next_q, t_next_d;
    logic                     sync_q, sync_d;
    logic [HB_X_W-1:0]        hb_x_q, hb_x_d;
    logic [HB_Y_W-1:0]        hb_y_q, hb_y_d;
    logic [HB_W_W-1:0]        hb_w_q, hb_w_d;
    logic [HB_H_W-1:0]        hb_h_q, hb_h_d;
    logic [HB_SENS_W-1:0]     hb_sens_q, hb_sens_d;
    logic                     pulse_q, pulse_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     tb_clear;

    game_time_base #(
        .MAXIMUM_TIMES (MAXIMUM_TIMES),
        .TICK_DIV      (TICK_DIV)
    ) u_time_base (
        .clk          (clk),
        .reset        (reset),
        .enable       (busy_q && !pause),
        .clear        (tb_clear),
        .current_time (current_time)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        t_next_d  = t_next_q;
        sync_d    = sync_q;
        hb_x_d    = hb_x_q;
        hb_y_d    = hb_y_q;
        hb_w_d    = hb_w_q;
        hb_h_d    = hb_h_q;
        hb_sens_d = hb_sens_q;
        pulse_d   = 1'b0;
        tb_clear  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                sync_d = 1'b1;
                if (start) begin
                    state_d  = ST_FETCH;
                    addr_d   = '0;
                    sync_d   = 1'b0;
                    tb_clear = 1'b1;
                end
            end
            ST_FETCH: begin
                sync_d = 1'b0;
                if (update_ui_time) begin
                    sync_d = 1'b1;
                    if (is_end) begin
`ifdef UI_SEQ_LOOP_EN
                        addr_d   = '0;
                        tb_clear = 1'b1;
                        state_d  = ST_ADV;
`else
                        state_d  = ST_DONE;
`endif
                    end else begin
                        hb_x_d    = rom_x;
                        hb_y_d    = rom_y;
                        hb_w_d    = rom_w;
                        hb_h_d    = rom_h;
                        hb_sens_d = rom_sens;
                        pulse_d   = rom_reset_hs;
                        t_next_d  = next_ui_time;
                        state_d   = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                sync_d = 1'b1;
                if (!update_ui_time) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                sync_d = 1'b1;
                if ((current_time >= t_next_q) && !pause) begin
                    // Running off the end of the ROM stops rather than wrapping to 0.
                    if (addr_q == '1) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        state_d = ST_ADV;
                    end
                end
            end
            ST_ADV: begin
                sync_d  = 1'b0;
                state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_IDLE;
                sync_d  = 1'b1;
            end
        endcase

        busy_d = is_busy_state(state_d);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            t_next_q  <= '0;
            sync_q    <= 1'b1;
            hb_x_q    <= '0;
            hb_y_q    <= '0;
            hb_w_q    <= '0;
            hb_h_q    <= '0;
            hb_sens_q <= '0;
            pulse_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            t_next_q  <= t_next_d;
            sync_q    <= sync_d;
            hb_x_q    <= hb_x_d;
            hb_y_q    <= hb_y_d;
            hb_w_q    <= hb_w_d;
            hb_h_q    <= hb_h_d;
            hb_sens_q <= hb_sens_d;
            pulse_q   <= pulse_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign addr           = addr_q;
    assign sync_ui_time   = sync_q;
    assign hb_x           = hb_x_q;
    assign hb_y           = hb_y_q;
    assign hb_w           = hb_w_q;
    assign hb_h           = hb_h_q;
    assign hb_sens        = hb_sens_q;
    assign hb_reset_pulse = pulse_q;
    assign busy           = busy_q;
    assign seq_done       = done_q;

endmodule

// File: tb/tb_game_ui_sequencer.sv
// Self-checking bench for game_ui_sequencer: a cycle model built from the
// sequencing rules, a per-cycle compare process and directed scenarios.
module tb_game_ui_sequencer;

    localparam int AW = 10;
    localparam int MT = 30;
    localparam int TD = 4;

    localparam int P_IDLE  = 0;
    localparam int P_FETCH = 1;
    localparam int P_ACK   = 2;
    localparam int P_WAIT  = 3;
    localparam int P_ADV   = 4;
    localparam int P_DONE  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          update_ui_time = 1'b0;
    logic [MT-1:0] next_ui_time = '0;
    logic          is_end = 1'b0;
    logic          rom_reset_hs = 1'b0;
    logic [9:0]    rom_x = '0, rom_y = '0, rom_w = '0, rom_h = '0;
    logic [6:0]    rom_sens = '0;

    logic [AW-1:0] addr;
    logic [MT-1:0] current_time;
    logic          sync_ui_time;
    logic [9:0]    hb_x, hb_y, hb_w, hb_h;
    logic [6:0]    hb_sens;
    logic          hb_reset_pulse, busy, seq_done;

    logic          s_start = 1'b0;
    logic [9:0]    s_addr;
    logic [3:0]    s_time;
    logic          s_sync;
    logic [9:0]    s_hb_x, s_hb_y, s_hb_w, s_hb_h;
    logic [6:0]    s_hb_sens;
    logic          s_pulse, s_busy, s_done;

    game_ui_sequencer #(.ADDR_WIDTH(AW), .MAXIMUM_TIMES(MT), .TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause),
        .update_ui_time(update_ui_time), .next_ui_time(next_ui_time),
        .is_end(is_end), .rom_reset_hs(rom_reset_hs),
        .rom_x(rom_x), .rom_y(rom_y), .rom_w(rom_w), .rom_h(rom_h), .rom_sens(rom_sens),
        .addr(addr), .current_time(current_time), .sync_ui_time(sync_ui_time),
        .hb_x(hb_x), .hb_y(hb_y), .hb_w(hb_w), .hb_h(hb_h), .hb_sens(hb_sens),
        .hb_reset_pulse(hb_reset_pulse), .busy(busy), .seq_done(seq_done)
    );

    game_ui_sequencer #(.ADDR_WIDTH(10), .MAXIMUM_TIMES(4), .TICK_DIV(2)) dut_sat (
        .clk(clk), .reset(reset), .start(s_start), .pause(1'b0),
        .update_ui_time(1'b0), .next_ui_time(4'd0),
        .is_end(1'b0), .rom_reset_hs(1'b0),
        .rom_x(10'd0), .rom_y(10'd0), .rom_w(10'd0), .rom_h(10'd0), .rom_sens(7'd0),
        .addr(s_addr), .current_time(s_time), .sync_ui_time(s_sync),
        .hb_x(s_hb_x), .hb_y(s_hb_y), .hb_w(s_hb_w), .hb_h(s_hb_h), .hb_sens(s_hb_sens),
        .hb_reset_pulse(s_pulse), .busy(s_busy), .seq_done(s_done)
    );

    int checks = 0;
    int errors = 0;
    int pulse_count = 0;
    bit run_cmp = 1'b0;

    // Reference model state
    int            m_phase = P_IDLE;
    logic [AW-1:0] m_addr = '0;
    longint        m_count = 0;
    longint        m_tnext = 0;
    logic          m_sync = 1'b1;
    logic          m_pulse = 1'b0;
    logic [9:0]    m_x = '0, m_y = '0, m_w = '0, m_h = '0;
    logic [6:0]    m_sens = '0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Game time is the number of enabled cycles divided by the tick length, capped.
    function automatic longint m_time();
        longint lim;
        longint t;
        lim = (longint'(1) << MT) - 1;
        t   = m_count / TD;
        return (t > lim) ? lim : t;
    endfunction

    function automatic bit m_busy();
        return (m_phase == P_FETCH) || (m_phase == P_ACK) || (m_phase == P_WAIT);
    endfunction

    task automatic model_step();
        longint t_now;
        if (reset) begin
            m_phase = P_IDLE; m_addr = '0; m_count = 0; m_tnext = 0;
            m_sync = 1'b1; m_pulse = 1'b0;
            m_x = '0; m_y = '0; m_w = '0; m_h = '0; m_sens = '0;
            return;
        end
        t_now = m_time();
        if (m_busy() && !pause) m_count++;
        m_pulse = 1'b0;
        case (m_phase)
            P_IDLE, P_DONE: if (start) begin
                m_phase = P_FETCH; m_addr = '0; m_count = 0; m_sync = 1'b0;
            end
            P_FETCH: if (update_ui_time) begin
                m_sync = 1'b1;
                if (is_end) begin
`ifdef UI_SEQ_LOOP_EN
                    m_addr = '0; m_count = 0; m_phase = P_ADV;
`else
                    m_phase = P_DONE;
`endif
                end else begin
                    m_x = rom_x; m_y = rom_y; m_w = rom_w; m_h = rom_h; m_sens = rom_sens;
                    m_pulse = rom_reset_hs;
                    m_tnext = longint'(next_ui_time);
                    m_phase = P_ACK;
                end
            end
            P_ACK: if (!update_ui_time) m_phase = P_WAIT;
            P_WAIT: if (t_now >= m_tnext && !pause) begin
                if (m_addr == '1) m_phase = P_DONE;
                else begin
                    m_addr = m_addr + 1'b1;
                    m_phase = P_ADV;
                end
            end
            P_ADV: begin
                m_phase = P_FETCH; m_sync = 1'b0;
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (run_cmp) begin
            checkOutput("addr", addr, m_addr);
            checkOutput("current_time", current_time, m_time());
            checkOutput("sync_ui_time", sync_ui_time, m_sync);
            checkOutput("hb_x", hb_x, m_x);
            checkOutput("hb_y", hb_y, m_y);
            checkOutput("hb_w", hb_w, m_w);
            checkOutput("hb_h", hb_h, m_h);
            checkOutput("hb_sens", hb_sens, m_sens);
            checkOutput("hb_reset_pulse", hb_reset_pulse, m_pulse);
            checkOutput("busy", busy, m_busy());
            checkOutput("seq_done", seq_done, m_phase == P_DONE);
            if (hb_reset_pulse === 1'b1) pulse_count++;
        end
    end

    // Act as the ROM reader: wait for a fetch request, then present one entry.
    task automatic applyStimulus(input int x, input int y, input int w, input int h,
                                 input int sens, input bit rhs, input int nxt,
                                 input bit end_flag, input int hold);
        for (int i = 0; i < 60 && sync_ui_time !== 1'b0; i++) @(negedge clk);
        checkOutput("fetch_request", sync_ui_time, 0);
        rom_x = 10'(x); rom_y = 10'(y); rom_w = 10'(w); rom_h = 10'(h);
        rom_sens = 7'(sens); rom_reset_hs = rhs;
        next_ui_time = MT'(nxt); is_end = end_flag;
        update_ui_time = 1'b1;
        repeat (hold) @(negedge clk);
        update_ui_time = 1'b0;
        is_end = 1'b0;
    endtask

    task automatic wait_addr(input int target, input int max_cycles, input string name);
        for (int i = 0; i < max_cycles && addr !== AW'(target); i++) @(negedge clk);
        checkOutput(name, addr, target);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    logic [MT-1:0] t_frozen;

    initial begin
        @(negedge clk);
        run_cmp = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        $display("[TB] reset values");
        checkOutput("rst_addr", addr, 0);
        checkOutput("rst_sync", sync_ui_time, 1);
        checkOutput("rst_busy", busy, 0);

        $display("[TB] entry 0: latch and advance at time 30");
        pulse_start();
        pulse_count = 0;
        applyStimulus(11, 22, 33, 44, 5, 1'b0, 30, 1'b0, 1);
        checkOutput("e0_hb_x", hb_x, 11);
        checkOutput("e0_hb_sens", hb_sens, 5);
        checkOutput("e0_sync_ack", sync_ui_time, 1);
        wait_addr(1, 30 * TD + 40, "e0_advance");
        checkOutput("e0_time_at_adv", current_time, 30);
        checkOutput("e0_no_pulse", pulse_count, 0);

        $display("[TB] entry 1: reset_healt_status pulse");
        pulse_count = 0;
        applyStimulus(101, 102, 103, 104, 77, 1'b1, 35, 1'b0, 1);
        checkOutput("e1_pulse_now", hb_reset_pulse, 1);
        wait_addr(2, 10 * TD + 40, "e1_advance");
        checkOutput("e1_one_pulse", pulse_count, 1);

        $display("[TB] entry 2: pause in WAIT and ignored start");
        applyStimulus(55, 66, 77, 88, 9, 1'b0, 40, 1'b0, 1);
        t_frozen = current_time;
        pause = 1'b1;
        repeat (50 * TD) @(negedge clk);
        checkOutput("pause_time_frozen", current_time, t_frozen);
        pulse_start();
        checkOutput("start_ignored_addr", addr, 2);
        checkOutput("start_ignored_busy", busy, 1);
        pause = 1'b0;
        wait_addr(3, 10 * TD + 40, "e2_advance");
        checkOutput("e2_time_at_adv", current_time, 40);

        $display("[TB] end marker at addr 3");
        applyStimulus(999, 999, 999, 999, 127, 1'b1, 0, 1'b1, 1);
`ifdef UI_SEQ_LOOP_EN
        checkOutput("loop_addr", addr, 0);
        checkOutput("loop_time", current_time, 0);
        checkOutput("loop_done", seq_done, 0);
`else
        checkOutput("end_done", seq_done, 1);
        checkOutput("end_sync", sync_ui_time, 1);
        checkOutput("end_hb_x_hold", hb_x, 55);
        checkOutput("end_hb_sens_hold", hb_sens, 9);
        checkOutput("end_busy", busy, 0);
`endif

        $display("[TB] next_ui_time already reached");
        pulse_start();
        applyStimulus(1, 2, 3, 4, 6, 1'b0, 0, 1'b0, 1);
        checkOutput("imm_ack_addr", addr, 0);
        @(negedge clk);
        checkOutput("imm_wait_addr", addr, 0);
        @(negedge clk);
        checkOutput("imm_exit_addr", addr, 1);

        $display("[TB] reset during ACK");
        for (int i = 0; i < 60 && sync_ui_time !== 1'b0; i++) @(negedge clk);
        checkOutput("ack_fetch_request", sync_ui_time, 0);
        rom_x = 10'd500; rom_sens = 7'd42; rom_reset_hs = 1'b1; next_ui_time = MT'(1000);
        update_ui_time = 1'b1;
        @(negedge clk);
        checkOutput("ack_latched", hb_x, 500);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_addr", addr, 0);
        checkOutput("mid_rst_time", current_time, 0);
        checkOutput("mid_rst_sync", sync_ui_time, 1);
        checkOutput("mid_rst_hb_x", hb_x, 0);
        checkOutput("mid_rst_hb_sens", hb_sens, 0);
        checkOutput("mid_rst_pulse", hb_reset_pulse, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_done", seq_done, 0);
        reset = 1'b0;
        update_ui_time = 1'b0;
        rom_reset_hs = 1'b0;
        @(negedge clk);

        $display("[TB] saturating time base");
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("sat_time_5", s_time, 5);
        checkOutput("sat_busy", s_busy, 1);
        repeat (40) @(negedge clk);
        checkOutput("sat_time_15", s_time, 15);
        repeat (20) @(negedge clk);
        checkOutput("sat_time_stays", s_time, 15);

        run_cmp = 1'b0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
